// File: rtl/iob_rst_cke_seq_pkg.sv
// Shared definitions for the reset / clock-enable sequencer.
// Holds the state encoding (ARST..RUN), the state width and the default
// parameter values so the top level and the bench agree on them.
package iob_rst_cke_seq_pkg;

  localparam int unsigned StateW = 3;

  typedef enum logic [StateW-1:0] {
    StArst = 3'd0,
    StLock = 3'd1,
    StHold = 3'd2,
    StCke  = 3'd3,
    StRun  = 3'd4
  } state_e;

  localparam int unsigned DefSyncStages = 2;
  localparam int unsigned DefHoldCycles = 16;
  localparam int unsigned DefCkeDelay   = 4;
  localparam int unsigned DefWdogCycles = 1024;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/iob_sync.sv
// Multi-flop synchronizer with asynchronous active-low clear.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous clear, active-low (all stages forced to 0)
//   d_i    - asynchronous input
//   q_o    - synchronized output (last stage)
module iob_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/iob_rst_cke_seq.sv
// Reset and clock-enable sequencer for the FPGA top level. Drives the arst/cke
// pair of the SoC memory wrapper: synchronizes board reset release, waits for
// PLL lock, holds the SoC in reset for HOLD_CYCLES, releases cke CKE_DELAY
// cycles later, and re-sequences on lock loss or a software reset request.
// Optional watchdog enabled by defining IOB_RST_CKE_SEQ_WDOG_EN.
// Ports:
//   clk_i        - system clock
//   resetn_i     - board reset, asynchronous, active-low
//   pll_locked_i - PLL lock, asynchronous to clk_i
//   sw_rst_i     - single-cycle software reset request (ignored in ARST/LOCK)
//   wdog_kick_i  - watchdog kick pulse
//   wdog_clr_i   - clears the sticky watchdog flag
//   arst_o       - active-high reset to the SoC
//   cke_o        - clock enable to the SoC
//   rst_done_o   - high only in RUN
//   state_o      - current state code
//   wdog_rst_o   - sticky: last reset was caused by the watchdog
module iob_rst_cke_seq
  import iob_rst_cke_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefSyncStages,
  parameter int unsigned HOLD_CYCLES = DefHoldCycles,
  parameter int unsigned CKE_DELAY   = DefCkeDelay,
  parameter int unsigned WDOG_CYCLES = DefWdogCycles
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              pll_locked_i,
  input  logic              sw_rst_i,
  input  logic              wdog_kick_i,
  input  logic              wdog_clr_i,
  output logic              arst_o,
  output logic              cke_o,
  output logic              rst_done_o,
  output logic [StateW-1:0] state_o,
  output logic              wdog_rst_o
);

  localparam int unsigned CntW = $clog2(max_u(HOLD_CYCLES, CKE_DELAY) + 1);

  logic rst_sync;
  logic lock_sync;
  logic wdog_set;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            arst_q, cke_q, done_q;

  // Reset path: async assert, release only after SYNC_STAGES edges.
  iob_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk_i (clk_i),
    .rst_ni(resetn_i),
    .d_i   (1'b1),
    .q_o   (rst_sync)
  );

  iob_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lock_sync (
    .clk_i (clk_i),
    .rst_ni(resetn_i),
    .d_i   (pll_locked_i),
    .q_o   (lock_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StArst: begin
        if (rst_sync) begin
          state_d = StLock;
          cnt_d   = '0;
        end
      end
      StLock: begin
        if (lock_sync) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold, StCke, StRun: begin
        if (!lock_sync) begin
          state_d = StLock;
          cnt_d   = '0;
        end else if (sw_rst_i || wdog_set) begin
          // Re-entering HOLD from HOLD restarts the count.
          state_d = StHold;
          cnt_d   = '0;
        end else if (state_q == StHold) begin
          if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
            state_d = StCke;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (state_q == StCke) begin
          if (cnt_q == CntW'(CKE_DELAY - 1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StArst;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StArst;
      cnt_q   <= '0;
      arst_q  <= 1'b1;
      cke_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arst_q  <= !(state_d inside {StCke, StRun});
      cke_q   <= (state_d == StRun);
      done_q  <= (state_d == StRun);
    end
  end

`ifdef IOB_RST_CKE_SEQ_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES);

  logic [WdogW-1:0] wdog_cnt_q, wdog_cnt_d;
  logic             wdog_flag_q, wdog_flag_d;
  logic             wdog_expire;

  assign wdog_expire = (state_q == StRun) && !wdog_kick_i &&
                       (wdog_cnt_q == WdogW'(WDOG_CYCLES - 1));
  // Lock loss and software reset outrank the watchdog as the cause.
  assign wdog_set    = wdog_expire && lock_sync && !sw_rst_i;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q + 1'b1;
    if ((state_q != StRun) || wdog_kick_i || wdog_expire) begin
      wdog_cnt_d = '0;
    end
    wdog_flag_d = wdog_flag_q;
    if (wdog_set) begin
      wdog_flag_d = 1'b1;
    end else if (wdog_clr_i) begin
      wdog_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wdog_cnt_q  <= '0;
      wdog_flag_q <= 1'b0;
    end else begin
      wdog_cnt_q  <= wdog_cnt_d;
      wdog_flag_q <= wdog_flag_d;
    end
  end

  assign wdog_rst_o = wdog_flag_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^{wdog_kick_i, wdog_clr_i, (WDOG_CYCLES == 0)};
  assign wdog_set    = 1'b0;
  assign wdog_rst_o  = 1'b0;
`endif

  assign arst_o     = arst_q;
  assign cke_o      = cke_q;
  assign rst_done_o = done_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_iob_rst_cke_seq.sv
// Self-checking bench for iob_rst_cke_seq: directed sequences plus a random
// phase, all compared against a cycle-level behavioural model.
module tb_iob_rst_cke_seq;

  localparam int unsigned SyncStages = 2;
  localparam int unsigned HoldCycles = 16;
  localparam int unsigned CkeDelay   = 4;
`ifdef IOB_RST_CKE_SEQ_WDOG_EN
  localparam bit          WdogOn     = 1'b1;
  localparam int unsigned WdogCycles = 8;
`else
  localparam bit          WdogOn     = 1'b0;
  localparam int unsigned WdogCycles = 1024;
`endif

  logic       clk = 1'b0;
  logic       resetn, pll_locked, sw_rst, wdog_kick, wdog_clr;
  logic       arst, cke, rst_done, wdog_rst;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  iob_rst_cke_seq #(
    .SYNC_STAGES(SyncStages),
    .HOLD_CYCLES(HoldCycles),
    .CKE_DELAY  (CkeDelay),
    .WDOG_CYCLES(WdogCycles)
  ) dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .pll_locked_i(pll_locked),
    .sw_rst_i    (sw_rst),
    .wdog_kick_i (wdog_kick),
    .wdog_clr_i  (wdog_clr),
    .arst_o      (arst),
    .cke_o       (cke),
    .rst_done_o  (rst_done),
    .state_o     (state),
    .wdog_rst_o  (wdog_rst)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model. States: 0 ARST, 1 LOCK, 2 HOLD, 3 CKE, 4 RUN.
  // m_left counts the cycles still to spend in HOLD/CKE; m_idle counts RUN
  // cycles since the last kick. Synchronized inputs are plain delay lines.
  int m_state, m_left, m_rel, m_idle, m_nxt;
  bit m_flag, m_rs, m_ls, m_fire, m_enter;
  bit m_lock[SyncStages];

  initial forever begin
    @(posedge clk or negedge resetn);
    if (!resetn) begin
      m_state = 0;
      m_left  = 0;
      m_rel   = 0;
      m_idle  = 0;
      m_flag  = 1'b0;
      for (int i = 0; i < int'(SyncStages); i++) m_lock[i] = 1'b0;
    end else begin
      m_rs    = (m_rel >= int'(SyncStages));
      m_ls    = m_lock[SyncStages-1];
      m_fire  = 1'b0;
      m_enter = 1'b0;
      m_nxt   = m_state;
      if (m_state == 0) begin
        if (m_rs) begin m_nxt = 1; m_enter = 1'b1; end
      end else if (m_state == 1) begin
        if (m_ls) begin m_nxt = 2; m_enter = 1'b1; end
      end else if (m_state >= 2 && m_state <= 4) begin
        if (!m_ls) begin
          m_nxt = 1; m_enter = 1'b1;
        end else if (sw_rst) begin
          m_nxt = 2; m_enter = 1'b1;
        end else if (WdogOn && m_state == 4 && !wdog_kick && m_idle == int'(WdogCycles) - 1) begin
          m_nxt = 2; m_enter = 1'b1; m_fire = 1'b1;
        end else if (m_state != 4) begin
          m_left--;
          if (m_left == 0) begin m_nxt = m_state + 1; m_enter = 1'b1; end
        end
      end else begin
        m_nxt = 0; m_enter = 1'b1;
      end
      if (m_enter) m_left = (m_nxt == 2) ? int'(HoldCycles) : (m_nxt == 3) ? int'(CkeDelay) : 0;
      if (m_state == 4 && m_nxt == 4 && !wdog_kick) m_idle++;
      else m_idle = 0;
      if (m_fire) m_flag = 1'b1;
      else if (wdog_clr) m_flag = 1'b0;
      if (m_rel < 1000) m_rel++;
      for (int i = int'(SyncStages) - 1; i > 0; i--) m_lock[i] = m_lock[i-1];
      m_lock[0] = pll_locked;
      m_state = m_nxt;
    end
  end

  // Compare every cycle on the inactive edge.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("mon_state", 32'(state), 32'(m_state));
      check("mon_arst", 32'(arst), 32'(m_state < 3));
      check("mon_cke", 32'(cke), 32'(m_state == 4));
      check("mon_done", 32'(rst_done), 32'(m_state == 4));
      check("mon_wdog", 32'(wdog_rst), 32'(m_flag));
      check("mon_cke_excl", 32'(cke & arst), 32'd0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  int rst_hold;

  initial begin
    resetn     = 1'b0;
    pll_locked = 1'b1;
    sw_rst     = 1'b0;
    wdog_kick  = 1'b1;
    wdog_clr   = 1'b0;
    tick(2);
    mon_en = 1'b1;
    tick(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_arst", 32'(arst), 32'd1);
    check("rst_cke", 32'(cke), 32'd0);
    check("rst_done", 32'(rst_done), 32'd0);
    check("rst_wdog", 32'(wdog_rst), 32'd0);

    // Power-up; edge 0 is the first edge that samples resetn high.
    resetn = 1'b1;
    for (int e = 0; e <= 23; e++) begin
      tick(1);
      if (e == 1) check("pwr_e1_arst_state", 32'(state), 32'd0);
      if (e == 2) check("pwr_e2_lock", 32'(state), 32'd1);
      if (e == 3) check("pwr_e3_hold", 32'(state), 32'd2);
      if (e == 18) check("pwr_e18_arst_high", 32'(arst), 32'd1);
      if (e == 19) check("pwr_e19_arst_fall", 32'(arst), 32'd0);
      if (e == 19) check("pwr_e19_cke_state", 32'(state), 32'd3);
      if (e == 22) check("pwr_e22_cke_low", 32'(cke), 32'd0);
      if (e == 23) check("pwr_e23_cke_rise", 32'(cke), 32'd1);
      if (e == 23) check("pwr_e23_done_rise", 32'(rst_done), 32'd1);
    end

    // Late lock.
    resetn = 1'b0;
    pll_locked = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(50);
    check("late_wait_lock", 32'(state), 32'd1);
    pll_locked = 1'b1;
    tick(2);
    check("late_still_lock", 32'(state), 32'd1);
    tick(1);
    check("late_hold", 32'(state), 32'd2);
    tick(15);
    check("late_hold_last", 32'(state), 32'd2);
    tick(1);
    check("late_cke", 32'(state), 32'd3);
    tick(3);
    check("late_cke_last", 32'(state), 32'd3);
    tick(1);
    check("late_run", 32'(state), 32'd4);

    // Lock loss in RUN, then relock.
    pll_locked = 1'b0;
    tick(2);
    check("loss_still_run", 32'(state), 32'd4);
    tick(1);
    check("loss_lock", 32'(state), 32'd1);
    check("loss_arst", 32'(arst), 32'd1);
    check("loss_cke", 32'(cke), 32'd0);
    pll_locked = 1'b1;
    tick(22);
    check("relock_cke", 32'(state), 32'd3);
    tick(1);
    check("relock_run", 32'(state), 32'd4);

    // Software reset from RUN.
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    check("sw_hold", 32'(state), 32'd2);
    check("sw_arst", 32'(arst), 32'd1);
    tick(19);
    check("sw_cke", 32'(state), 32'd3);
    tick(1);
    check("sw_rerun", 32'(state), 32'd4);

    // Second pulse mid-HOLD restarts the count.
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    tick(8);
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    tick(15);
    check("sw_restart_hold", 32'(state), 32'd2);
    tick(1);
    check("sw_restart_cke", 32'(state), 32'd3);
    tick(4);
    check("sw_restart_run", 32'(state), 32'd4);

    // Software reset while synced lock is low: LOCK wins.
    pll_locked = 1'b0;
    tick(2);
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    check("sw_vs_lock", 32'(state), 32'd1);
    pll_locked = 1'b1;
    tick(23);
    check("sw_vs_lock_run", 32'(state), 32'd4);

    // Async reset while in CKE, checked without a clock edge.
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    tick(17);
    check("async_pre_cke", 32'(state), 32'd3);
    #2;
    resetn = 1'b0;
    #1;
    check("async_state", 32'(state), 32'd0);
    check("async_arst", 32'(arst), 32'd1);
    check("async_cke", 32'(cke), 32'd0);
    check("async_done", 32'(rst_done), 32'd0);
    tick(3);
    resetn = 1'b1;
    tick(24);
    check("async_rerun", 32'(state), 32'd4);

`ifdef IOB_RST_CKE_SEQ_WDOG_EN
    // No kick for WdogCycles RUN cycles; clear in the same cycle loses.
    wdog_kick = 1'b0;
    tick(7);
    check("wd_pre_expire", 32'(state), 32'd4);
    wdog_clr = 1'b1;
    tick(1);
    wdog_clr = 1'b0;
    check("wd_expire_hold", 32'(state), 32'd2);
    check("wd_set_beats_clr", 32'(wdog_rst), 32'd1);
    wdog_kick = 1'b1;
    tick(20);
    check("wd_rerun", 32'(state), 32'd4);
    check("wd_sticky", 32'(wdog_rst), 32'd1);
    wdog_clr = 1'b1;
    tick(1);
    wdog_clr = 1'b0;
    check("wd_cleared", 32'(wdog_rst), 32'd0);
    for (int i = 0; i < 70; i++) begin
      wdog_kick = (i % 7 == 0);
      tick(1);
    end
    check("wd_kick7_run", 32'(state), 32'd4);
    check("wd_kick7_flag", 32'(wdog_rst), 32'd0);
    wdog_kick = 1'b1;
`else
    wdog_kick = 1'b0;
    tick(40);
    check("wd_off_state", 32'(state), 32'd4);
    check("wd_off_flag", 32'(wdog_rst), 32'd0);
    wdog_kick = 1'b1;
`endif

    // Random phase.
    rst_hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 149) == 0) pll_locked = !pll_locked;
      sw_rst    = ($urandom_range(0, 299) == 0);
      wdog_kick = WdogOn ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
      wdog_clr  = ($urandom_range(0, 39) == 0);
      if (!resetn) begin
        if (rst_hold == 0) resetn = 1'b1;
        else rst_hold--;
      end else if ($urandom_range(0, 1499) == 0) begin
        resetn   = 1'b0;
        rst_hold = 3;
      end
      tick(1);
    end

    tick(2);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
